tokenizer: RTL and testbench

- Downstream of the token buffer (`ds`). Consumes the `mem` token array when the keyboard's `eval_pulse` fires.
- Snapshots the buffer, then scans it left to right. Multi-digit runs are merged into binary numbers.
- Emits a stream of NUM / OP / END tokens over a valid/ready handshake to the future evaluator stage.

---
 rtl/tokenizer.sv | 155 +++++++++++++++
 tb/tb_tokenizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tokenizer.sv
// Tokenizer: snapshots the ds token buffer on eval, merges digit runs into
// binary numbers and streams NUM/OP/END tokens over a valid/ready handshake.
module tokenizer #(
    parameter int depth    = 20,
    parameter int width    = 8,
    parameter int numWidth = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                eval,
    input  logic [width-1:0]    mem [depth],
    output logic                tok_valid,
    input  logic                tok_ready,
    output logic [1:0]          tok_type,
    output logic [numWidth-1:0] tok_value,
    output logic                busy,
    output logic                err
);
    localparam int IdxW = $clog2(depth + 1);
    localparam int AccW = numWidth + 4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(depth);
    localparam logic [1:0] TypeNum = 2'd0;
    localparam logic [1:0] TypeOp  = 2'd1;
    localparam logic [1:0] TypeEnd = 2'd2;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, WAIT_END} state_t;

    state_t              state;
    logic [width-1:0]    snap [depth];
    logic [IdxW-1:0]     idx;
    logic [numWidth-1:0] acc;
    logic                have_num;

    logic [width-1:0]    cur;
    logic                at_end;
    logic                is_term;
    logic                is_digit;
    logic                is_op;
    logic [AccW-1:0]     acc_next;
    logic                overflow;

    // Slot selection as a compare-mux so idx==depth never indexes past snap.
    always_comb begin
        cur = '1;
        for (int i = 0; i < depth; i++) begin
            if (idx == IdxW'(i)) begin
                cur = snap[i];
            end
        end
    end

    assign at_end   = (idx == LastIdx);
    assign is_term  = at_end || (cur == width'(8'hFF));
    assign is_digit = !at_end && (cur <= width'(8'h09));
    assign is_op    = !at_end && (cur >= width'(8'h0A)) && (cur <= width'(8'h0F));

    // Four guard bits hold acc*10+9 exactly, so any spill above numWidth is overflow.
    assign acc_next = ({4'b0000, acc} * AccW'(10)) + AccW'(cur[3:0]);
    assign overflow = |acc_next[AccW-1:numWidth];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tok_valid <= 1'b0;
            tok_type  <= 2'd0;
            tok_value <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            acc       <= '0;
            have_num  <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (eval) begin
                        snap     <= mem;
                        idx      <= '0;
                        acc      <= '0;
                        have_num <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    tok_valid <= 1'b1;
                    if (is_term) begin
                        if (have_num) begin
                            tok_type  <= TypeNum;
                            tok_value <= acc;
                            acc       <= '0;
                            have_num  <= 1'b0;
                            state     <= WAIT;
                        end else begin
                            tok_type  <= TypeEnd;
                            tok_value <= '0;
                            state     <= WAIT_END;
                        end
                    end else if (is_digit) begin
                        if (overflow) begin
                            err       <= 1'b1;
                            tok_type  <= TypeEnd;
                            tok_value <= '0;
                            acc       <= '0;
                            have_num  <= 1'b0;
                            state     <= WAIT_END;
                        end else begin
                            tok_valid <= 1'b0;
                            acc       <= acc_next[numWidth-1:0];
                            have_num  <= 1'b1;
                            idx       <= idx + 1'b1;
                        end
                    end else if (is_op) begin
                        // A pending number goes out first; the operator is re-examined next scan.
                        if (have_num) begin
                            tok_type  <= TypeNum;
                            tok_value <= acc;
                            acc       <= '0;
                            have_num  <= 1'b0;
                        end else begin
                            tok_type  <= TypeOp;
                            tok_value <= numWidth'(cur);
                            idx       <= idx + 1'b1;
                        end
                        state <= WAIT;
                    end else begin
                        err       <= 1'b1;
                        tok_type  <= TypeEnd;
                        tok_value <= '0;
                        acc       <= '0;
                        have_num  <= 1'b0;
                        state     <= WAIT_END;
                    end
                end
                WAIT: begin
                    if (tok_ready) begin
                        tok_valid <= 1'b0;
                        state     <= SCAN;
                    end
                end
                WAIT_END: begin
                    if (tok_ready) begin
                        tok_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tokenizer.sv
// Randomized bench for tokenizer: three instances (32, 8 and 80 bit numbers)
// are compared against a token-list reference model computed from the buffer.
module tb_tokenizer;
    localparam int Depth = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  eval_vec;
    logic [7:0]  mem [Depth];
    logic        tok_ready;
    logic [2:0]  tok_valid;
    logic [1:0]  typ [3];
    logic [31:0] val32;
    logic [7:0]  val8;
    logic [79:0] val80;
    logic [2:0]  busy;
    logic [2:0]  err;

    int          assert_count = 0;
    int          fail_count   = 0;
    int          widths [3] = '{32, 8, 80};
    logic [7:0]  model_mem [Depth];
    logic [127:0] got_q [3][$];
    logic [127:0] exp_q [3][$];
    bit          exp_err [3];
    logic [127:0] prev_tok [3];
    bit          prev_hold [3];

    always #5 clock = ~clock;

    tokenizer #(.depth(Depth), .width(8), .numWidth(32)) dut32 (
        .clock(clock), .reset(reset), .eval(eval_vec[0]), .mem(mem),
        .tok_valid(tok_valid[0]), .tok_ready(tok_ready), .tok_type(typ[0]),
        .tok_value(val32), .busy(busy[0]), .err(err[0]));
    tokenizer #(.depth(Depth), .width(8), .numWidth(8)) dut8 (
        .clock(clock), .reset(reset), .eval(eval_vec[1]), .mem(mem),
        .tok_valid(tok_valid[1]), .tok_ready(tok_ready), .tok_type(typ[1]),
        .tok_value(val8), .busy(busy[1]), .err(err[1]));
    tokenizer #(.depth(Depth), .width(8), .numWidth(80)) dut80 (
        .clock(clock), .reset(reset), .eval(eval_vec[2]), .mem(mem),
        .tok_valid(tok_valid[2]), .tok_ready(tok_ready), .tok_type(typ[2]),
        .tok_value(val80), .busy(busy[2]), .err(err[2]));

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] cur_tok(input int d);
        logic [95:0] v;
        v = (d == 0) ? 96'(val32) : (d == 1) ? 96'(val8) : 96'(val80);
        return 128'({typ[d], v});
    endfunction

    function automatic logic [127:0] mk_tok(input logic [1:0] t, input logic [95:0] v);
        return 128'({t, v});
    endfunction

    // Reference: walk the buffer once, producing the whole token list at once.
    task automatic build_expected(input int d, input int w);
        logic [255:0] acc;
        logic [255:0] lim;
        logic [7:0]   c;
        bit           have;
        exp_q[d].delete();
        exp_err[d] = 0;
        acc  = '0;
        have = 0;
        lim  = (256'd1 << w) - 256'd1;
        for (int i = 0; i <= Depth; i++) begin
            c = (i == Depth) ? 8'hFF : model_mem[i];
            if (c <= 8'h09) begin
                acc = acc * 10 + 256'(c);
                if (acc > lim) begin
                    exp_err[d] = 1;
                    exp_q[d].push_back(mk_tok(2'd2, '0));
                    return;
                end
                have = 1;
            end else if (c <= 8'h0F) begin
                if (have) exp_q[d].push_back(mk_tok(2'd0, acc[95:0]));
                have = 0;
                acc  = '0;
                exp_q[d].push_back(mk_tok(2'd1, 96'(c)));
            end else begin
                if (c == 8'hFF && have) exp_q[d].push_back(mk_tok(2'd0, acc[95:0]));
                if (c != 8'hFF) exp_err[d] = 1;
                exp_q[d].push_back(mk_tok(2'd2, '0));
                return;
            end
        end
    endtask

    // Collect transfers and require tok_* to hold while a token is stalled.
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                prev_hold[d] = 0;
            end else begin
                if (prev_hold[d]) begin
                    checkOutput($sformatf("hold%0d_valid", d), 128'(tok_valid[d]), 128'd1);
                    checkOutput($sformatf("hold%0d_tok", d), cur_tok(d), prev_tok[d]);
                end
                if (tok_valid[d] && tok_ready) got_q[d].push_back(cur_tok(d));
                prev_hold[d] = tok_valid[d] && !tok_ready;
                prev_tok[d]  = cur_tok(d);
            end
        end
    end

    task automatic setMem(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
        for (int i = 0; i < Depth; i++) mem[i] = 8'hFF;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = e;
    endtask

    task automatic randomMem();
        int r;
        for (int i = 0; i < Depth; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      mem[i] = 8'($urandom_range(0, 9));
            else if (r < 82) mem[i] = 8'($urandom_range(10, 15));
            else if (r < 92) mem[i] = 8'hFF;
            else             mem[i] = 8'($urandom_range(16, 254));
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: five stall cycles after first valid
    task automatic applyStimulus(input logic [2:0] mask, input int mode, input bit poke);
        int cyc;
        int stalls;
        model_mem = mem;
        for (int d = 0; d < 3; d++) begin
            got_q[d].delete();
            if (mask[d]) build_expected(d, widths[d]);
        end
        tok_ready = 1'b1;
        @(posedge clock); #1 eval_vec = mask;
        @(posedge clock); #1 eval_vec = 3'b000;
        cyc    = 0;
        stalls = 0;
        while ((busy & mask) != 3'b000 && cyc < 400) begin
            case (mode)
                1:       tok_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (tok_valid[0] && stalls < 5) begin
                        tok_ready = 1'b0;
                        stalls++;
                    end else begin
                        tok_ready = 1'b1;
                    end
                end
                default: tok_ready = 1'b1;
            endcase
            if (poke && cyc == 3) begin
                eval_vec = mask;
                mem[3]   = 8'h0A;
            end else begin
                eval_vec = 3'b000;
            end
            @(posedge clock); #1;
            cyc++;
        end
        eval_vec  = 3'b000;
        tok_ready = 1'b1;
        checkOutput("timeout", 128'(cyc < 400), 128'd1);
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                checkOutput($sformatf("count%0d", d), 128'(got_q[d].size()), 128'(exp_q[d].size()));
                for (int k = 0; k < got_q[d].size() && k < exp_q[d].size(); k++)
                    checkOutput($sformatf("tok%0d_%0d", d, k), got_q[d][k], exp_q[d][k]);
                checkOutput($sformatf("err%0d", d), 128'(err[d]), 128'(exp_err[d]));
                checkOutput($sformatf("busy%0d", d), 128'(busy[d]), 128'd0);
            end
        end
    endtask

    task automatic checkTiming();
        tok_ready = 1'b1;
        setMem(8'h0A, 8'hFF, 8'hFF, 8'hFF);
        @(posedge clock); #1 eval_vec = 3'b001;
        @(posedge clock); #1 eval_vec = 3'b000;
        @(negedge clock);
        checkOutput("op_c1_busy", 128'(busy[0]), 128'd1);
        checkOutput("op_c1_valid", 128'(tok_valid[0]), 128'd0);
        @(negedge clock);
        checkOutput("op_c2_valid", 128'(tok_valid[0]), 128'd1);
        checkOutput("op_c2_tok", cur_tok(0), mk_tok(2'd1, 96'h0A));
        @(negedge clock);
        checkOutput("op_c3_valid", 128'(tok_valid[0]), 128'd0);
        @(negedge clock);
        checkOutput("op_c4_tok", cur_tok(0), mk_tok(2'd2, '0));
        checkOutput("op_c4_busy", 128'(busy[0]), 128'd1);
        @(negedge clock);
        checkOutput("op_c5_busy", 128'(busy[0]), 128'd0);
        checkOutput("op_c5_valid", 128'(tok_valid[0]), 128'd0);

        setMem(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        @(posedge clock); #1 eval_vec = 3'b001;
        @(posedge clock); #1 eval_vec = 3'b000;
        @(negedge clock);
        checkOutput("empty_c1_busy", 128'(busy[0]), 128'd1);
        checkOutput("empty_c1_valid", 128'(tok_valid[0]), 128'd0);
        @(negedge clock);
        checkOutput("empty_c2_tok", cur_tok(0), mk_tok(2'd2, '0));
        checkOutput("empty_c2_busy", 128'(busy[0]), 128'd1);
        @(negedge clock);
        checkOutput("empty_c3_busy", 128'(busy[0]), 128'd0);
        checkOutput("empty_c3_err", 128'(err[0]), 128'd0);
    endtask

    task automatic checkResetMidScan();
        tok_ready = 1'b1;
        for (int i = 0; i < Depth; i++) mem[i] = 8'h09;
        @(posedge clock); #1 eval_vec = 3'b100;
        @(posedge clock); #1 eval_vec = 3'b000;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("pre_reset_busy", 128'(busy[2]), 128'd1);
        for (int d = 0; d < 3; d++) got_q[d].delete();
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_valid", 128'(tok_valid[2]), 128'd0);
        checkOutput("rst_tok", cur_tok(2), 128'd0);
        checkOutput("rst_busy", 128'(busy[2]), 128'd0);
        checkOutput("rst_err8", 128'(err[1]), 128'd0);
        @(negedge clock); #2 reset = 1'b0;
        repeat (10) @(negedge clock);
        checkOutput("rst_no_end", 128'(got_q[2].size()), 128'd0);
        checkOutput("rst_idle_busy", 128'(busy[2]), 128'd0);
        checkOutput("rst_idle_valid", 128'(tok_valid[2]), 128'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        eval_vec  = 3'b000;
        tok_ready = 1'b1;
        for (int i = 0; i < Depth; i++) mem[i] = 8'hFF;
        #23 reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset%0d_valid", d), 128'(tok_valid[d]), 128'd0);
            checkOutput($sformatf("reset%0d_tok", d), cur_tok(d), 128'd0);
            checkOutput($sformatf("reset%0d_busy_err", d), 128'({busy[d], err[d]}), 128'd0);
        end

        checkTiming();

        setMem(8'h01, 8'h02, 8'h0A, 8'h03);
        applyStimulus(3'b111, 0, 0);
        applyStimulus(3'b111, 2, 0);

        setMem(8'h03, 8'h00, 8'h00, 8'hFF);
        applyStimulus(3'b111, 0, 0);
        setMem(8'h02, 8'h05, 8'h05, 8'hFF);
        applyStimulus(3'b111, 0, 0);

        setMem(8'h01, 8'h20, 8'h02, 8'hFF);
        applyStimulus(3'b111, 0, 0);
        setMem(8'h01, 8'h02, 8'h0A, 8'h03);
        applyStimulus(3'b111, 1, 0);

        for (int i = 0; i < Depth; i++) mem[i] = 8'h09;
        applyStimulus(3'b100, 0, 1);
        for (int i = 0; i < Depth; i++) mem[i] = 8'h09;
        applyStimulus(3'b111, 1, 0);

        for (int n = 0; n < 30; n++) begin
            randomMem();
            applyStimulus(3'b111, 1, 0);
        end

        checkResetMidScan();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
